// File: rtl/poly_pm_if.sv
// PolyMul-port bus between the pointwise engine (master) and the polynomial memory (slave).
// Handshake: pm_req (reads) and pm_we (write) are the valid side, pm_stall is an inverted combinational ready; a cycle transfers only when pm_stall is low.
interface poly_pm_if #(
  parameter int NUM_BANKS = 4,
  parameter int N         = 256,
  parameter int W         = 16
);
  localparam int ADDR_W = $clog2(N);
  localparam int BW     = $clog2(NUM_BANKS);

  logic              pm_req;
  logic [BW-1:0]     pm_bank_r0;
  logic [ADDR_W-1:0] pm_addr_r0;
  logic [W-1:0]      pm_rdata_r0;
  logic [BW-1:0]     pm_bank_r1;
  logic [ADDR_W-1:0] pm_addr_r1;
  logic [W-1:0]      pm_rdata_r1;
  logic [BW-1:0]     pm_bank_w;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr_w;
  logic [W-1:0]      pm_wdata;
  logic              pm_stall;

  modport master (
    output pm_req, pm_bank_r0, pm_addr_r0, pm_bank_r1, pm_addr_r1,
    output pm_bank_w, pm_we, pm_addr_w, pm_wdata,
    input  pm_rdata_r0, pm_rdata_r1, pm_stall
  );

  modport slave (
    input  pm_req, pm_bank_r0, pm_addr_r0, pm_bank_r1, pm_addr_r1,
    input  pm_bank_w, pm_we, pm_addr_w, pm_wdata,
    output pm_rdata_r0, pm_rdata_r1, pm_stall
  );
endinterface

// File: rtl/poly_pointwise_engine.sv
// Streams C[i] = A[i] +/- B[i] mod Q through the PolyMul port, one coefficient per cycle,
// with a one-entry hold register that keeps a computed result alive across pm_stall.
module poly_pointwise_engine #(
  parameter int NUM_BANKS = 4,
  parameter int N         = 256,
  parameter int W         = 16,
  parameter int ADDR_W    = $clog2(N),
  parameter int Q         = 3329,
  localparam int BW       = $clog2(NUM_BANKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op,
  input  logic [BW-1:0] src_a_bank,
  input  logic [BW-1:0] src_b_bank,
  input  logic [BW-1:0] dst_bank,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          dbg_state,
  poly_pm_if.master     pm
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [ADDR_W:0]   RD_END  = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(N-1);
  localparam logic [W:0]        Q_EXT   = (W+1)'(Q);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              rd_pending_q, rd_pending_d;
  logic              hold_valid_q, hold_valid_d;
  logic [W-1:0]      hold_data_q, hold_data_d;
  logic              op_q, op_d;
  logic [BW-1:0]     bank_a_q, bank_a_d;
  logic [BW-1:0]     bank_b_q, bank_b_d;
  logic [BW-1:0]     bank_w_q, bank_w_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              run;
  logic              accept;
  logic              rd_issue;
  logic              wr_valid;
  logic [W:0]        sum_ext;
  logic [W:0]        diff_ext;
  logic [W-1:0]      f_res;
  logic [W-1:0]      wdata_mux;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    sum_ext  = {1'b0, pm.pm_rdata_r0} + {1'b0, pm.pm_rdata_r1};
    diff_ext = {1'b0, pm.pm_rdata_r0} - {1'b0, pm.pm_rdata_r1};
    if (pm.pm_rdata_r0 < pm.pm_rdata_r1) begin
      diff_ext = diff_ext + Q_EXT;
    end
    if (op_q) begin
      f_res = diff_ext[W-1:0];
    end else if (sum_ext >= Q_EXT) begin
      f_res = W'(sum_ext - Q_EXT);
    end else begin
      f_res = sum_ext[W-1:0];
    end
  end

  assign run       = (state_q == S_RUN);
  assign accept    = ~pm.pm_stall;
  assign rd_issue  = run && (rd_idx_q < RD_END);
  assign wr_valid  = hold_valid_q | rd_pending_q;
  assign wdata_mux = hold_valid_q ? hold_data_q : f_res;
  // Past the last coefficient the read address parks on N-1 so it never leaves the bank.
  assign rd_addr   = (rd_idx_q >= RD_END) ? LAST_IX : rd_idx_q[ADDR_W-1:0];

  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    wr_idx_d     = wr_idx_q;
    rd_pending_d = rd_pending_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    op_d         = op_q;
    bank_a_d     = bank_a_q;
    bank_b_d     = bank_b_q;
    bank_w_d     = bank_w_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (src_a_bank != src_b_bank) begin
            state_d      = S_RUN;
            op_d         = op;
            bank_a_d     = src_a_bank;
            bank_b_d     = src_b_bank;
            bank_w_d     = dst_bank;
            rd_idx_d     = '0;
            wr_idx_d     = '0;
            rd_pending_d = 1'b0;
            hold_valid_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        rd_pending_d = accept && rd_issue;
        if (accept && rd_issue) begin
          rd_idx_d = rd_idx_q + (ADDR_W+1)'(1);
        end
        if (wr_valid) begin
          if (accept) begin
            wr_idx_d     = wr_idx_q + ADDR_W'(1);
            hold_valid_d = 1'b0;
            if (wr_idx_q == LAST_IX) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else if (rd_pending_q) begin
            // The read data is only valid this cycle, so park the result before it is lost.
            hold_data_d  = f_res;
            hold_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      rd_pending_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      op_q         <= 1'b0;
      bank_a_q     <= '0;
      bank_b_q     <= '0;
      bank_w_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      rd_pending_q <= rd_pending_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      op_q         <= op_d;
      bank_a_q     <= bank_a_d;
      bank_b_q     <= bank_b_d;
      bank_w_q     <= bank_w_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy      = run;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign pm.pm_req     = run;
  assign pm.pm_bank_r0 = run ? bank_a_q : '0;
  assign pm.pm_bank_r1 = run ? bank_b_q : '0;
  assign pm.pm_addr_r0 = run ? rd_addr : '0;
  assign pm.pm_addr_r1 = run ? rd_addr : '0;
  assign pm.pm_bank_w  = run ? bank_w_q : '0;
  assign pm.pm_we      = run & wr_valid;
  assign pm.pm_addr_w  = run ? wr_idx_q : '0;
  assign pm.pm_wdata   = (run && wr_valid) ? wdata_mux : '0;

endmodule

// File: tb/tb_poly_pointwise_engine.sv
// Bench for poly_pointwise_engine: bank memory model on the PolyMul port, modular
// add/sub reference model, scheduled and random pm_stall patterns.
module tb_poly_pointwise_engine;
  localparam int NUM_BANKS = 4;
  localparam int N         = 256;
  localparam int W         = 16;
  localparam int Q         = 3329;
  localparam int ADDR_W    = $clog2(N);
  localparam int BW        = $clog2(NUM_BANKS);
  localparam int MAX_CYC   = 1500;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, op;
  logic [BW-1:0] src_a_bank, src_b_bank, dst_bank;
  logic          busy, done, err, dbg_state;

  poly_pm_if #(.NUM_BANKS(NUM_BANKS), .N(N), .W(W)) pm_bus ();

  poly_pointwise_engine #(.NUM_BANKS(NUM_BANKS), .N(N), .W(W), .Q(Q)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .src_a_bank (src_a_bank),
    .src_b_bank (src_b_bank),
    .dst_bank   (dst_bank),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state),
    .pm         (pm_bus.master)
  );

  // memory model: 1-cycle read latency, stalled cycles have no effect
  logic [W-1:0]  mem [NUM_BANKS][N];
  logic [W-1:0]  stage [N];
  logic          ld_en, clr_stats;
  logic [BW-1:0] ld_bank;
  int            hits [N];
  int            we_cycles;

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < N; i++) mem[ld_bank][i] <= stage[i];
    end
    if (clr_stats) begin
      for (int i = 0; i < N; i++) hits[i] <= 0;
      we_cycles <= 0;
    end else if (pm_bus.pm_we) begin
      we_cycles <= we_cycles + 1;
      if (!pm_bus.pm_stall) begin
        mem[pm_bus.pm_bank_w][pm_bus.pm_addr_w] <= pm_bus.pm_wdata;
        hits[pm_bus.pm_addr_w] <= hits[pm_bus.pm_addr_w] + 1;
      end
    end
    if (pm_bus.pm_req && !pm_bus.pm_stall) begin
      pm_bus.pm_rdata_r0 <= mem[pm_bus.pm_bank_r0][pm_bus.pm_addr_r0];
      pm_bus.pm_rdata_r1 <= mem[pm_bus.pm_bank_r1][pm_bus.pm_addr_r1];
    end
  end

  // scoreboard
  logic [W-1:0] exp_q [$];
  bit           stall_pat [MAX_CYC+2];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic o, input int a, input int b);
    int r;
    r = o ? (a - b + Q) % Q : (a + b) % Q;
    return W'(r);
  endfunction

  // RUN needs N+1 accepted cycles; every stalled cycle inside the run pushes done out by one.
  function automatic int exp_done_cycle();
    int c, acc;
    c = 1;
    acc = 0;
    while (acc < N + 1 && c <= MAX_CYC) begin
      if (!stall_pat[c]) acc++;
      c++;
    end
    return c;
  endfunction

  // driver tasks
  task automatic load_bank(input logic [BW-1:0] b, input int mode, input int val);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       stage[i] = W'(i);
        1:       stage[i] = W'(val);
        default: stage[i] = W'($urandom_range(0, Q-1));
      endcase
    end
    ld_bank = b;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic set_stalls(input int pct, input int w0, input int w1, input int w2);
    for (int c = 0; c < MAX_CYC + 2; c++) begin
      stall_pat[c] = ($urandom_range(0, 99) < pct);
      if ((w0 >= 0 && c >= w0 && c < w0 + 3) || (w1 >= 0 && c >= w1 && c < w1 + 3) ||
          (w2 >= 0 && c >= w2 && c < w2 + 3)) stall_pat[c] = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_req"}, pm_bus.pm_req, 0);
    check({tag, "_we"}, pm_bus.pm_we, 0);
    check({tag, "_addr_bank"}, {pm_bus.pm_addr_r0, pm_bus.pm_addr_r1, pm_bus.pm_addr_w,
          pm_bus.pm_bank_r0, pm_bus.pm_bank_r1, pm_bus.pm_bank_w}, 0);
    check({tag, "_wdata"}, pm_bus.pm_wdata, 0);
  endtask

  task automatic run_op(input logic o, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] d, input int restart_at, input int rst_at,
                        input bit check_we);
    int rel, done_cyc, bad;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(ref_op(o, mem[a][i], mem[b][i]));
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats  = 1'b0;
    start      = 1'b1;
    op         = o;
    src_a_bank = a;
    src_b_bank = b;
    dst_bank   = d;
    pm_bus.pm_stall = stall_pat[0];
    rel = 0;
    done_cyc = -1;
    while (rel < MAX_CYC && done_cyc < 0) begin
      @(negedge clk);
      rel++;
      start = 1'b0;
      if (done) done_cyc = rel;
      if (rel == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        pm_bus.pm_stall = 1'b0;
        return;
      end
      if (rel == restart_at) begin
        start      = 1'b1;
        op         = ~o;
        src_a_bank = 2'd3;
        src_b_bank = 2'd2;
        dst_bank   = 2'd0;
      end
      pm_bus.pm_stall = stall_pat[rel];
    end
    pm_bus.pm_stall = 1'b0;
    check("done_cycle", done_cyc, exp_done_cycle());
    check("idle_after_done", busy, 0);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("req_in_idle", pm_bus.pm_req, 0);
    for (int i = 0; i < N; i++) check("c_data", mem[d][i], exp_q.pop_front());
    bad = 0;
    for (int i = 0; i < N; i++) if (hits[i] != 1) bad++;
    check("indices_not_written_once", bad, 0);
    if (check_we) check("we_cycles", we_cycles, N);
  endtask

  initial begin
    logic [BW-1:0] ra, rb, rd;
    logic          ro;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    src_a_bank = '0;
    src_b_bank = '0;
    dst_bank = '0;
    ld_en = 1'b0;
    ld_bank = '0;
    clr_stats = 1'b1;
    pm_bus.pm_stall = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr_stats = 1'b0;

    // add, ramp + constant, no stalls
    set_stalls(0, -1, -1, -1);
    load_bank(2'd0, 0, 0);
    load_bank(2'd1, 1, 3000);
    run_op(1'b0, 2'd0, 2'd1, 2'd2, -1, -1, 1'b1);
    check("c0_add", mem[2][0], 3000);
    check("c255_add", mem[2][255], 3255);

    // subtract with borrow, then without borrow in place
    load_bank(2'd0, 1, 5);
    load_bank(2'd1, 1, 10);
    run_op(1'b1, 2'd0, 2'd1, 2'd3, -1, -1, 1'b1);
    check("sub_wrap", mem[3][17], 3324);
    load_bank(2'd0, 1, 10);
    load_bank(2'd1, 1, 5);
    run_op(1'b1, 2'd0, 2'd1, 2'd0, -1, -1, 1'b1);
    check("sub_inplace", mem[0][200], 5);

    // stall windows, including on the final write
    load_bank(2'd0, 0, 0);
    load_bank(2'd1, 2, 0);
    set_stalls(0, 50, 120, 257);
    run_op(1'b0, 2'd0, 2'd1, 2'd2, -1, -1, 1'b0);

    // rejected start
    set_stalls(0, -1, -1, -1);
    @(negedge clk);
    start = 1'b1;
    src_a_bank = 2'd1;
    src_b_bank = 2'd1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_req", pm_bus.pm_req, 0);
    @(negedge clk);
    check("err_single", err, 0);
    check("err_stays_idle", busy, 0);

    // start during RUN is ignored
    load_bank(2'd1, 2, 0);
    load_bank(2'd2, 2, 0);
    run_op(1'b1, 2'd1, 2'd2, 2'd3, 10, -1, 1'b1);

    // reset mid-operation, then a full run
    run_op(1'b0, 2'd1, 2'd2, 2'd3, -1, 100, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    load_bank(2'd0, 2, 0);
    run_op(1'b0, 2'd0, 2'd2, 2'd1, -1, -1, 1'b1);

    // random ops with random stalls
    for (int t = 0; t < 4; t++) begin
      ra = BW'($urandom_range(0, NUM_BANKS-1));
      rb = BW'((int'(ra) + $urandom_range(1, NUM_BANKS-1)) % NUM_BANKS);
      rd = BW'($urandom_range(0, NUM_BANKS-1));
      ro = 1'($urandom_range(0, 1));
      load_bank(ra, 2, 0);
      load_bank(rb, 2, 0);
      set_stalls(25, -1, -1, -1);
      run_op(ro, ra, rb, rd, -1, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
